// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1:2 packet demux
package demux_pkg;

  localparam int DEMUX_WIDTH = 16;
  localparam int BUF_DEPTH   = 2;
  localparam int BUF_CNTW    = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_e;

  function automatic logic route_bit(input state_e st, input logic sel);
    // IDLE follows the live in_sel; a route state pins the port for the packet.
    case (st)
      ROUTE0:  route_bit = 1'b0;
      ROUTE1:  route_bit = 1'b1;
      default: route_bit = sel;
    endcase
  endfunction

endpackage

// File: rtl/demux_out_buf.sv
// rtl/demux_out_buf.sv - two-entry FIFO-ordered valid/ready output buffer
module demux_out_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0]    head_q, head_d;
  logic [WIDTH-1:0]    tail_q, tail_d;
  logic [BUF_CNTW-1:0] count_q, count_d;
  logic                pop;

  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign full      = (count_q == BUF_CNTW'(BUF_DEPTH));
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == '0) begin
          head_d = push_data;
        end else begin
          tail_d = push_data;
        end
        count_d = count_q + BUF_CNTW'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - BUF_CNTW'(1);
      end
      2'b11: begin
        // Simultaneous push/pop keeps the occupancy; the new word lands behind any survivor.
        if (count_q == BUF_CNTW'(1)) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: begin
        head_d  = head_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/packet_demux_1to2.sv
// rtl/packet_demux_1to2.sv - packet-aware 1:2 word demux with per-port buffers and counters
module packet_demux_1to2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  state_e          state_q;
  logic            tgt;
  logic            full0, full1;
  logic            in_xfer;
  logic            push0, push1;
  logic [CNTW-1:0] cnt0_q, cnt0_d;
  logic [CNTW-1:0] cnt1_q, cnt1_d;

  assign tgt      = route_bit(state_q, in_sel);
  // Readiness only looks at the target buffer, never at the consumer's ready.
  assign in_ready = !rst && (tgt ? !full1 : !full0);
  assign in_xfer  = in_valid & in_ready;
  assign push0    = in_xfer & !tgt;
  assign push1    = in_xfer & tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (in_xfer) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_q <= in_sel ? ROUTE1 : ROUTE0;
          end
        end
        ROUTE0, ROUTE1: begin
          if (in_last) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  demux_out_buf #(.WIDTH(WIDTH)) u_buf0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .full      (full0),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  (out0_data)
  );

  demux_out_buf #(.WIDTH(WIDTH)) u_buf1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .full      (full1),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data)
  );

  always_comb begin
    cnt0_d = cnt0_q + CNTW'(out0_valid & out0_ready);
    cnt1_d = cnt1_q + CNTW'(out1_valid & out1_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_packet_demux_1to2.sv
// tb/tb_packet_demux_1to2.sv - scoreboard bench for packet_demux_1to2
module tb_packet_demux_1to2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_last;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [15:0] out1_data;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  int checks   = 0;
  int failures = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        m_busy  = 1'b0;
  logic        m_route = 1'b0;

  always #5 clk = ~clk;

  packet_demux_1to2 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out0_valid && out0_ready) begin
      if (q0.size() == 0) check("out0_unexpected", 32'd1, 32'd0);
      else check("out0_data", {16'd0, out0_data}, {16'd0, q0.pop_front()});
    end
    if (!rst && out1_valid && out1_ready) begin
      if (q1.size() == 0) check("out1_unexpected", 32'd1, 32'd0);
      else check("out1_data", {16'd0, out1_data}, {16'd0, q1.pop_front()});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic sel, input logic last);
    logic tgt;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = sel;
    in_last  = last;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        tgt  = m_busy ? m_route : sel;
        if (tgt) q1.push_back(d);
        else q0.push_back(d);
        m_busy  = !last;
        m_route = tgt;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    m_busy = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 16'hDEAD;
    in_sel     = 1'b0;
    in_last    = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;

    // 1. Reset with in_valid held high
    cycles(2);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("rst_out0_data", {16'd0, out0_data}, 32'd0);
    check("rst_out1_data", {16'd0, out1_data}, 32'd0);
    check("rst_cnt0", {16'd0, cnt0}, 32'd0);
    check("rst_cnt1", {16'd0, cnt1}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    cycles(1);

    // 2. Single-beat packets
    send(16'h1234, 1'b0, 1'b1);
    @(negedge clk);
    check("single_out0_valid", {31'd0, out0_valid}, 32'd1);
    check("single_out0_word", {16'd0, out0_data}, 32'h1234);
    @(posedge clk);
    #1;
    send(16'hABCD, 1'b1, 1'b1);
    @(negedge clk);
    check("single_out1_valid", {31'd0, out1_valid}, 32'd1);
    check("single_out1_word", {16'd0, out1_data}, 32'hABCD);
    cycles(3);
    check("single_cnt0", {16'd0, cnt0}, 32'd1);
    check("single_cnt1", {16'd0, cnt1}, 32'd1);

    // 3. Three-beat packet to out1, in_sel toggled mid-packet
    send(16'h0001, 1'b1, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    send(16'h0003, 1'b0, 1'b1);
    cycles(3);
    check("pkt_cnt0", {16'd0, cnt0}, 32'd1);
    check("pkt_cnt1", {16'd0, cnt1}, 32'd4);
    send(16'h0077, 1'b0, 1'b1);
    cycles(3);
    check("pkt_idle_cnt0", {16'd0, cnt0}, 32'd2);

    // 4. Backpressure on out0
    out0_ready = 1'b0;
    send(16'h0A01, 1'b0, 1'b0);
    send(16'h0A02, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'h0A03;
    in_sel   = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, out0_valid}, 32'd1);
      check("bp_hold_data", {16'd0, out0_data}, 32'h0A01);
      @(posedge clk);
      #1;
    end
    out0_ready = 1'b1;
    send(16'h0A03, 1'b1, 1'b1);
    cycles(4);
    check("bp_drained", {31'd0, q0.size() == 0}, 32'd1);
    check("bp_cnt0", {16'd0, cnt0}, 32'd5);

    // 5. Reset mid-packet discards buffered beat
    out0_ready = 1'b0;
    send(16'h0B01, 1'b0, 1'b0);
    do_reset(1);
    @(negedge clk);
    check("mid_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("mid_cnt0", {16'd0, cnt0}, 32'd0);
    @(posedge clk);
    #1;
    out0_ready = 1'b1;
    send(16'h5555, 1'b1, 1'b1);
    cycles(3);
    check("mid_cnt1", {16'd0, cnt1}, 32'd1);
    check("mid_cnt0_after", {16'd0, cnt0}, 32'd0);

    // 6. Counter wrap on out0
    do_reset(1);
    for (int i = 0; i < 65535; i++) send(16'(i), 1'b0, 1'b1);
    cycles(3);
    check("wrap_cnt0_max", {16'd0, cnt0}, 32'hFFFF);
    send(16'hFFFF, 1'b0, 1'b1);
    cycles(3);
    check("wrap_cnt0_zero", {16'd0, cnt0}, 32'd0);
    check("wrap_cnt1", {16'd0, cnt1}, 32'd0);
    check("wrap_q_empty", {31'd0, q0.size() == 0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
